// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the two-port data memory arbiter: ownership states and
// the bundle of fields a requester presents with each access.
package data_memory_arbiter_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned BE_W        = 4;
   localparam int unsigned STARVE_CNT_W = 4;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] address;
      logic [DATA_W-1:0] write_data;
      logic [BE_W-1:0]   byte_enable;
      logic              write;
      logic              lock;
   } port_req_t;

   function automatic port_req_t idle_req();
      return '0;
   endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// One requester port of the arbiter: access request in, grant and read
// response out. The master side belongs to the requester.
interface data_memory_arbiter_if;
   import data_memory_arbiter_pkg::*;

   logic              req;
   port_req_t         acc;
   logic              grant;
   logic              rvalid;
   logic [DATA_W-1:0] read_data;

   modport master (
      output req,
      output acc,
      input  grant,
      input  rvalid,
      input  read_data
   );

   modport slave (
      input  req,
      input  acc,
      output grant,
      output rvalid,
      output read_data
   );

endinterface

// File: rtl/data_memory_arbiter_starve_counter.sv
// Saturating count of consecutive port-0 wins while port 1 is waiting;
// at_limit tells the arbiter it is port 1's turn.
module arbiter_starve_counter
   import data_memory_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic clear,
   output logic at_limit
);

   logic [STARVE_CNT_W-1:0] count_q;
   logic [STARVE_CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != STARVE_CNT_W'(LIMIT))) begin
         count_d = count_q + STARVE_CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign at_limit = (count_q == STARVE_CNT_W'(LIMIT));

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a synchronous data memory: fixed port-0
// priority with starvation relief for port 1, plus bus locking per port.
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   data_memory_arbiter_if.slave  p0,
   data_memory_arbiter_if.slave  p1,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W-1:0]     mem_write_data,
   output logic [BE_W-1:0]       mem_byte_enable,
   output logic                  mem_read_enable,
   output logic                  mem_write_enable,
   input  logic [DATA_W-1:0]     mem_read_data
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic       grant0_raw;
   logic       grant1_raw;
   logic       grant0;
   logic       grant1;
   logic       starve_at_limit;
   logic       rd0_q;
   logic       rd0_d;
   logic       rd1_q;
   logic       rd1_d;
   port_req_t  sel_acc;
   logic       sel_valid;

   arbiter_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clock    (clock),
      .reset    (reset),
      .inc      (grant0_raw & p1.req),
      .clear    (grant1_raw | ~p1.req),
      .at_limit (starve_at_limit)
   );

   always_comb begin
      grant0_raw = 1'b0;
      grant1_raw = 1'b0;
      case (state_q)
         FREE: begin
            if (p0.req && p1.req) begin
               grant1_raw = starve_at_limit;
               grant0_raw = ~starve_at_limit;
            end else begin
               grant0_raw = p0.req;
               grant1_raw = p1.req;
            end
         end
         OWN0:    grant0_raw = p0.req;
         OWN1:    grant1_raw = p1.req;
         default: ;
      endcase
   end

   // A granted access with lock keeps the bus; a granted unlocked access
   // releases it. Cycles without a grant never change ownership.
   always_comb begin
      state_d = state_q;
      if (grant0_raw) begin
         state_d = p0.acc.lock ? OWN0 : FREE;
      end else if (grant1_raw) begin
         state_d = p1.acc.lock ? OWN1 : FREE;
      end else if (state_q != FREE && state_q != OWN0 && state_q != OWN1) begin
         state_d = FREE;
      end
   end

   always_comb begin
      rd0_d = grant0_raw & ~p0.acc.write;
      rd1_d = grant1_raw & ~p1.acc.write;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= FREE;
         rd0_q   <= 1'b0;
         rd1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end

   // Outputs are gated by reset so nothing is granted while it is asserted,
   // even though the grant logic itself is combinational.
   assign grant0 = grant0_raw & reset;
   assign grant1 = grant1_raw & reset;

   always_comb begin
      sel_acc   = idle_req();
      sel_valid = 1'b0;
      if (grant0) begin
         sel_acc   = p0.acc;
         sel_valid = 1'b1;
      end else if (grant1) begin
         sel_acc   = p1.acc;
         sel_valid = 1'b1;
      end
   end

   assign mem_address      = sel_acc.address;
   assign mem_write_data   = sel_acc.write_data;
   assign mem_byte_enable  = sel_acc.byte_enable;
   assign mem_read_enable  = sel_valid & ~sel_acc.write;
   assign mem_write_enable = sel_valid & sel_acc.write;

   assign p0.grant     = grant0;
   assign p1.grant     = grant1;
   assign p0.rvalid    = rd0_q;
   assign p1.rvalid    = rd1_q;
   assign p0.read_data = rd0_q ? mem_read_data : '0;
   assign p1.read_data = rd1_q ? mem_read_data : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: directed scenarios then random
// traffic, checked against an ownership/priority model and a memory array.
module tb_data_memory_arbiter;
   import data_memory_arbiter_pkg::*;

   localparam int unsigned LIMIT = 4;

   typedef struct {
      int          port;
      logic [31:0] data;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_byte_enable;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic [31:0] mem_read_data = '0;

   data_memory_arbiter_if p0_if ();
   data_memory_arbiter_if p1_if ();

   data_memory_arbiter #(
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .p0               (p0_if),
      .p1               (p1_if),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_byte_enable  (mem_byte_enable),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .mem_read_data    (mem_read_data)
   );

   always #5 clock = ~clock;

   logic [31:0] dev_mem   [256];
   logic [31:0] model_mem [256];
   exp_t        sb [$];
   int          owner    = -1;
   int          wait_cnt = 0;
   int          last_win = 0;
   int          passes   = 0;
   int          total    = 0;

   // Synchronous memory device on the arbiter's memory bus.
   always @(posedge clock) begin
      if (mem_write_enable) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) dev_mem[mem_address[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
         end
      end
      if (mem_read_enable) mem_read_data <= dev_mem[mem_address[9:2]];
   end

   task automatic check_value(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic port_req_t mk_req(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] be, input logic wr, input logic lk);
      port_req_t r;
      r.address = a; r.write_data = d; r.byte_enable = be; r.write = wr; r.lock = lk;
      return r;
   endfunction

   function automatic port_req_t rd(input logic [31:0] a, input logic lk);
      return mk_req(a, 32'h0, 4'hF, 1'b0, lk);
   endfunction

   function automatic port_req_t rand_req();
      return mk_req({22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, 4'($urandom),
                    ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 20));
   endfunction

   // Reference: who should win this cycle, what the bus must carry, and what
   // read response the scoreboard should expect next cycle.
   task automatic check_output(input logic r0, input port_req_t q0, input logic r1, input port_req_t q1);
      int        w;
      port_req_t a;
      logic      exp_re, exp_we;
      w = 0;
      if (owner == 0)      w = r0 ? 1 : 0;
      else if (owner == 1) w = r1 ? 2 : 0;
      else if (r0 && r1)   w = (wait_cnt == int'(LIMIT)) ? 2 : 1;
      else if (r0)         w = 1;
      else if (r1)         w = 2;
      a = (w == 1) ? q0 : (w == 2) ? q1 : idle_req();
      exp_re = (w != 0) && !a.write;
      exp_we = (w != 0) && a.write;
      check_value("grant", {p1_if.grant, p0_if.grant}, (w == 2) ? 2'b10 : (w == 1) ? 2'b01 : 2'b00);
      check_value("mem_bus",
                  {mem_address, mem_write_data, mem_byte_enable, mem_read_enable, mem_write_enable},
                  {a.address, a.write_data, a.byte_enable, exp_re, exp_we});
      if (w != 0) begin
         if (a.write) begin
            for (int b = 0; b < 4; b++)
               if (a.byte_enable[b]) model_mem[a.address[9:2]][8*b +: 8] = a.write_data[8*b +: 8];
         end else begin
            sb.push_back('{port: w - 1, data: model_mem[a.address[9:2]]});
         end
         owner = a.lock ? (w - 1) : -1;
      end
      if (w == 2 || !r1)                      wait_cnt = 0;
      else if (w == 1 && wait_cnt < int'(LIMIT)) wait_cnt++;
      last_win = w;
   endtask

   task automatic apply_stimulus(input logic r0, input port_req_t q0, input logic r1, input port_req_t q1);
      @(negedge clock);
      p0_if.req = r0; p0_if.acc = q0;
      p1_if.req = r1; p1_if.acc = q1;
      #2;
      check_output(r0, q0, r1, q1);
   endtask

   task automatic idle_cycle();
      apply_stimulus(1'b0, idle_req(), 1'b0, idle_req());
   endtask

   // Monitor: any read granted last cycle must respond now, in grant order.
   initial begin : monitor
      exp_t        e;
      logic [1:0]  ev;
      logic [31:0] ed0, ed1;
      forever begin
         @(posedge clock);
         #1;
         ev = 2'b00; ed0 = '0; ed1 = '0;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            ev[e.port] = 1'b1;
            if (e.port == 0) ed0 = e.data; else ed1 = e.data;
         end
         check_value("rvalid", {p1_if.rvalid, p0_if.rvalid}, ev);
         check_value("read_data", {p1_if.read_data, p0_if.read_data}, {ed1, ed0});
      end
   end

   initial begin : stimulus
      p0_if.req = 1'b0; p0_if.acc = idle_req();
      p1_if.req = 1'b0; p1_if.acc = idle_req();
      for (int i = 0; i < 256; i++) begin
         dev_mem[i]   = $urandom;
         model_mem[i] = dev_mem[i];
      end
      dev_mem[8'h40]   = 32'hDEADBEEF;
      model_mem[8'h40] = 32'hDEADBEEF;

      // Held in reset with a request pending: nothing may be granted.
      repeat (2) @(negedge clock);
      p0_if.req = 1'b1; p0_if.acc = rd(32'h100, 1'b0);
      #1;
      check_value("reset_grant", {p1_if.grant, p0_if.grant}, 2'b00);
      check_value("reset_mem_en", {mem_read_enable, mem_write_enable}, 2'b00);
      @(negedge clock);
      reset = 1'b1;
      p0_if.req = 1'b0; p0_if.acc = idle_req();

      // Single read returning a known word.
      apply_stimulus(1'b1, rd(32'h100, 1'b0), 1'b0, idle_req());
      idle_cycle();

      // Both ports streaming reads: port 1 wins every fifth cycle.
      for (int i = 0; i < 15; i++) begin
         apply_stimulus(1'b1, rd({22'd0, 8'(i), 2'b00}, 1'b0), 1'b1, rd({22'd0, 8'(i + 100), 2'b00}, 1'b0));
         check_value("starve_seq", 128'(last_win), 128'((i % 5 == 4) ? 2 : 1));
      end
      idle_cycle();

      // Port 1 locks the bus; port 0 is shut out until it unlocks.
      apply_stimulus(1'b0, idle_req(), 1'b1, rd(32'h10, 1'b1));
      repeat (3) apply_stimulus(1'b1, rd(32'h20, 1'b0), 1'b0, idle_req());
      apply_stimulus(1'b1, rd(32'h20, 1'b0), 1'b1, rd(32'h14, 1'b0));
      apply_stimulus(1'b1, rd(32'h20, 1'b0), 1'b0, idle_req());
      idle_cycle();

      // Partial write beside a competing read, then read the merged word back.
      apply_stimulus(1'b1, mk_req(32'h200, 32'h12345678, 4'b0011, 1'b1, 1'b0), 1'b1, rd(32'h30, 1'b0));
      apply_stimulus(1'b0, idle_req(), 1'b1, rd(32'h30, 1'b0));
      apply_stimulus(1'b1, rd(32'h200, 1'b0), 1'b0, idle_req());
      idle_cycle();

      // Reset mid-cycle while port 1 owns the bus and a read is in flight.
      apply_stimulus(1'b0, idle_req(), 1'b1, rd(32'h44, 1'b1));
      apply_stimulus(1'b1, rd(32'h48, 1'b0), 1'b1, rd(32'h4C, 1'b1));
      reset = 1'b0;
      sb.delete();
      #1;
      check_value("async_reset_grant", {p1_if.grant, p0_if.grant}, 2'b00);
      check_value("async_reset_mem_en", {mem_read_enable, mem_write_enable}, 2'b00);
      check_value("async_reset_rvalid", {p1_if.rvalid, p0_if.rvalid}, 2'b00);
      @(negedge clock);
      reset = 1'b1;
      owner = -1; wait_cnt = 0;
      p0_if.req = 1'b0; p1_if.req = 1'b0;
      apply_stimulus(1'b1, rd(32'h50, 1'b0), 1'b1, rd(32'h54, 1'b1));
      idle_cycle();

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         apply_stimulus(($urandom_range(0, 99) < 70), rand_req(), ($urandom_range(0, 99) < 70), rand_req());
      end
      repeat (2) idle_cycle();
      @(negedge clock);
      check_value("scoreboard_drained", 128'(sb.size()), 128'(0));

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
